// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared types and constants for the parametrised single-port RAM.
package sp_ram_pkg;

   // Result reported on DO for an accepted write
   typedef enum logic [1:0] {
      NORMAL            = 2'd0,
      WRITE_THROUGH     = 2'd1,
      READ_BEFORE_WRITE = 2'd2
   } write_mode_e;

   // Read pipeline depth selection
   localparam int RM_BYPASS   = 0;
   localparam int RM_PIPELINE = 1;

   // Clear sequencer states
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage : sp_ram_pkg

// File: rtl/sp_ram_bank.sv
// sp_ram_bank: word-addressed storage array with a byte-enable write port
// and a registered read port. The caller picks, per access, whether the
// read register captures the stored word or the freshly merged write word.
module sp_ram_bank #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 512,
   localparam int BE_W   = DATA_W / 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] ad,
   input  logic [DATA_W-1:0] di,
   input  logic              ld,
   input  logic              ld_new,
   output logic [DATA_W-1:0] q
);

   // Replace the bytes selected by be_v, keep the rest of the old word
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [BE_W-1:0]   be_v
   );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < BE_W; i++) begin
         if (be_v[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

   // Array contents are not touched by reset; simulation starts from zero
   logic [DATA_W-1:0] mem_r [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] old_s;
   logic [DATA_W-1:0] merged_s;
   logic [DATA_W-1:0] q_r;

   // Stored word at the addressed location and its byte-merged update
   always_comb begin
      old_s    = mem_r[ad];
      merged_s = merge_bytes(old_s, di, be);
   end

   // Write port: merged word replaces the stored word
   always_ff @(posedge CLK) begin
      if (en && we) begin
         mem_r[ad] <= merged_s;
      end
   end

   // Read register: loads only when a new result is produced, holds otherwise
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         q_r <= '0;
      end else if (ld) begin
         q_r <= ld_new ? merged_s : old_s;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule : sp_ram_bank

// File: rtl/sp_ram_param.sv
// sp_ram_param: single-port RAM with byte enables, selectable write result,
// 1- or 2-stage read path with valid flag, and a one-word-per-cycle clear
// sequencer that owns the array while BUSY is high.
module sp_ram_param
   import sp_ram_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int DEPTH      = 512,
   parameter  int READ_MODE  = 0,
   parameter  int WRITE_MODE = 0,
   parameter  int INIT_CLEAR = 1,
   localparam int BE_W       = DATA_W / 8,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              CE,
   input  logic              OCE,
   input  logic              WRE,
   input  logic [BE_W-1:0]   BE,
   input  logic [ADDR_W-1:0] AD,
   input  logic [DATA_W-1:0] DI,
   input  logic              CLR,
   output logic [DATA_W-1:0] DO,
   output logic              DO_VALID,
   output logic              BUSY
);

   localparam write_mode_e WM        = write_mode_e'(WRITE_MODE[1:0]);
   localparam state_e      RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e              state_r;
   logic [ADDR_W-1:0]   cnt_r;
   logic                busy_r;

   logic                bank_en_s;
   logic                bank_we_s;
   logic [BE_W-1:0]     bank_be_s;
   logic [ADDR_W-1:0]   bank_ad_s;
   logic [DATA_W-1:0]   bank_di_s;
   logic                bank_ld_s;
   logic                bank_ld_new_s;
   logic [DATA_W-1:0]   bank_q_s;
   logic                s1_vld_r;

   // Clear sequencer: owns the array from CLR (or reset) until DEPTH-1 is written
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r <= RST_STATE;
         cnt_r   <= '0;
         busy_r  <= (INIT_CLEAR != 0);
      end else begin
         case (state_r)
            IDLE: begin
               if (CLR) begin
                  state_r <= CLEAR;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= cnt_r;
                  busy_r  <= 1'b0;
               end
            end
            CLEAR: begin
               // CLR is ignored here so a second pulse cannot extend BUSY
               if (cnt_r == LAST_ADDR) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= CLEAR;
                  cnt_r   <= cnt_r + ADDR_W'(1);
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Array port steering: clear writes while busy, user access otherwise.
   // A write only produces a result when the write mode reports one.
   always_comb begin
      bank_en_s     = 1'b0;
      bank_we_s     = 1'b0;
      bank_be_s     = '0;
      bank_ad_s     = '0;
      bank_di_s     = '0;
      bank_ld_s     = 1'b0;
      bank_ld_new_s = 1'b0;
      if (!RESETN) begin
         // Array is frozen while reset is held
         bank_en_s = 1'b0;
         bank_ld_s = 1'b0;
      end else if (state_r == CLEAR) begin
         bank_en_s = 1'b1;
         bank_we_s = 1'b1;
         bank_be_s = '1;
         bank_ad_s = cnt_r;
         bank_di_s = '0;
      end else begin
         bank_en_s     = CE;
         bank_we_s     = WRE;
         bank_be_s     = BE;
         bank_ad_s     = AD;
         bank_di_s     = DI;
         bank_ld_s     = CE && (!WRE || (WM != NORMAL));
         bank_ld_new_s = WRE && (WM == WRITE_THROUGH);
      end
   end

   sp_ram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank (
      .CLK    (CLK),
      .RESETN (RESETN),
      .en     (bank_en_s),
      .we     (bank_we_s),
      .be     (bank_be_s),
      .ad     (bank_ad_s),
      .di     (bank_di_s),
      .ld     (bank_ld_s),
      .ld_new (bank_ld_new_s),
      .q      (bank_q_s)
   );

   // Stage-1 valid: marks that the bank read register took a new result
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         s1_vld_r <= 1'b0;
      end else begin
         s1_vld_r <= bank_ld_s;
      end
   end

   generate
      if (READ_MODE == RM_PIPELINE) begin : g_pipe
         logic [DATA_W-1:0] do_r;
         logic              vld_r;

         // Output register: advance stage 1 when OCE, otherwise drop the result
         always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
               do_r  <= '0;
               vld_r <= 1'b0;
            end else if (OCE) begin
               vld_r <= s1_vld_r;
               if (s1_vld_r) begin
                  do_r <= bank_q_s;
               end else begin
                  do_r <= do_r;
               end
            end else begin
               do_r  <= do_r;
               vld_r <= 1'b0;
            end
         end

         assign DO       = do_r;
         assign DO_VALID = vld_r;
      end else begin : g_bypass
         logic unused_oce_s;
         assign unused_oce_s = OCE;
         assign DO       = bank_q_s;
         assign DO_VALID = s1_vld_r;
      end
   endgenerate

   assign BUSY = busy_r;

endmodule : sp_ram_param

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port RAM, successor to the fixed-geometry SP RAM primitive model, for line buffers and feature-map scratch storage. Generalises data width and depth, adds per-byte write enables, selectable read-during-write behaviour, a 1- or 2-stage read pipeline with a valid flag, and a hardware clear sequencer that zeroes the array one word per cycle. Sits between datapath engines and on-chip block RAM; synthesisable and usable as the simulation model.

## Interface
- DATA_W, 32: word width; multiple of 8, range 8..64
- DEPTH, 512: words; power of two, ≥ 4
- READ_MODE, 0: 0 = BYPASS (read latency 1), 1 = PIPELINE (latency 2, extra output register gated by OCE)
- WRITE_MODE, 0: 0 = NORMAL, 1 = WRITE_THROUGH, 2 = READ_BEFORE_WRITE
- INIT_CLEAR, 1: 1 = run clear sequence automatically after reset release
- Derived: BE_W = DATA_W/8, ADDR_W = $clog2(DEPTH)
- CLK  in  1  clock; all logic on rising edge
- RESETN  in  1  asynchronous, active-low reset
- CE  in  1  access request; accepted when CE=1 and BUSY=0
- OCE  in  1  output-register enable (PIPELINE only; ignored in BYPASS)
- WRE  in  1  1 = write, 0 = read
- BE  in  BE_W  byte enables for writes; bit i covers DI[8i+7:8i]
- AD  in  ADDR_W  word address
- DI  in  DATA_W  write data
- CLR  in  1  single-cycle pulse starting a clear sequence
- DO  out  DATA_W  read data
- DO_VALID  out  1  DO updated this cycle with a new result
- BUSY  out  1  clear sequence in progress; accesses refused

## Operation
- States: IDLE, CLEAR. Reset state = CLEAR if INIT_CLEAR else IDLE; clear counter = 0.
- IDLE: CLR=1 → CLEAR, counter = 0. CE ignored only when BUSY.
- CLEAR: writes 0 to mem[counter] each cycle, counter+1; after writing DEPTH-1 → IDLE. Takes exactly DEPTH cycles. CLR in CLEAR ignored (no restart). CE/WRE ignored, no DO_VALID.
- Write (accepted, WRE=1): bytes with BE[i]=1 replaced by DI; others kept. BE=0 → no change.
- Read (accepted, WRE=0): returns mem[AD].
- Write result on DO per WRITE_MODE: NORMAL → DO holds, no DO_VALID; WRITE_THROUGH → DO = merged new word, DO_VALID; READ_BEFORE_WRITE → DO = old word, DO_VALID.
- Memory array is not cleared by RESETN; contents survive reset unless a clear sequence runs. Initial simulation contents = 0.
- DO holds its last value when no new result arrives.

## Timing
- Reset values: DO = 0, DO_VALID = 0, BUSY = INIT_CLEAR, pipeline valid bits = 0.
- BYPASS: access accepted at edge N → DO/DO_VALID at edge N (visible in cycle N+1); DO_VALID high exactly one cycle per result.
- PIPELINE: stage 1 captured at edge N; at edge N+1, if OCE=1 stage 1 moves to DO with DO_VALID=1; if OCE=0 DO holds, DO_VALID=0, and that result is dropped (no back-pressure).
- Back-to-back accesses every cycle sustain one result per cycle in both modes.
- Read directly after write to the same address returns the new data (no hazard).
- BUSY rises on the edge sampling CLR in IDLE, falls on the edge writing DEPTH-1; CE in the BUSY-fall cycle's successor is accepted.
- RESETN assertion mid-clear or mid-read: outputs return to reset values immediately; in-flight results discarded; partially cleared memory stays partially cleared; clear restarts at 0 after release if INIT_CLEAR.

## Structure
- Package sp_ram_pkg: write_mode_e (NORMAL, WRITE_THROUGH, READ_BEFORE_WRITE), read-mode constants, state_e (IDLE, CLEAR).
- Sub-module sp_ram_bank: storage array with byte-enable write port and registered read; top holds clear FSM, mode muxing, output pipeline, valid tracking.

## Test plan
- INIT_CLEAR=1, DEPTH=16: release reset → BUSY high exactly 16 cycles; then read all addresses → all 0, DO_VALID one cycle each.
- Write 0xDEADBEEF @5, then BE=4'b0010 DI=0x0000AA00 @5, read @5 → 0xDEADAABEF-merge = 0xDEADAAEF.
- WRITE_MODE=2, mem[3]=0x11111111, write 0x22222222 @3 → DO=0x11111111 with DO_VALID; next read @3 → 0x22222222; WRITE_MODE=1 same stimulus → DO=0x22222222.
- READ_MODE=1: reads @0..3 back-to-back, OCE low on second result cycle → DO_VALID pattern 1,0,1,1 at latency 2, dropped word absent.
- CLR mid-traffic: CE requests during BUSY produce no DO_VALID and no writes; second CLR pulse mid-clear does not extend BUSY beyond DEPTH cycles.
- Assert RESETN at clear counter 7: DO=0, DO_VALID=0 immediately; after release BUSY high DEPTH cycles from address 0.
